// File: rtl/gbe_tx_arb_pkg.sv
// ============================================================================
// Module      : gbe_tx_arb_pkg
// Description : Shared types and helpers for the GbE UDP transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gbe_tx_arb_pkg;

    localparam int c_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    // Width of a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // First set bit of pending at or after ptr, searching cyclically over num_req lanes.
    function automatic logic [c_MAX_REQ-1:0] rr_pick(
        input logic [c_MAX_REQ-1:0] pending,
        input logic [2:0]           ptr,
        input int                   num_req
    );
        logic [c_MAX_REQ-1:0] grant;
        int                   idx;
        grant = '0;
        for (int k = 0; k < c_MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % num_req;
            if ((k < num_req) && (grant == '0) && pending[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gbe_tx_rr_pick.sv
// ============================================================================
// Module      : gbe_tx_rr_pick
// Description : Combinational round-robin priority encoder (one-hot grant).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gbe_tx_rr_pick
    import gbe_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
)(
    input  logic [NUM_REQ-1:0] pending,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [c_MAX_REQ-1:0] w_pend_ext;
    logic [2:0]           w_ptr_ext;
    logic [c_MAX_REQ-1:0] w_pick;

    always_comb begin
        w_pend_ext              = '0;
        w_pend_ext[NUM_REQ-1:0] = pending;
        w_ptr_ext               = '0;
        w_ptr_ext[PTR_W-1:0]    = ptr;
        w_pick                  = rr_pick(w_pend_ext, w_ptr_ext, NUM_REQ);
    end

    assign grant = w_pick[NUM_REQ-1:0];
    assign valid = |w_pick;

endmodule

`default_nettype wire

// File: rtl/gbe_tx_arbiter.sv
// ============================================================================
// Module      : gbe_tx_arbiter
// Description : Packet-granular round-robin arbiter feeding the GbE core's
//               8-bit app_tx port; truncates runaway packets and inserts an
//               idle gap. Optional statistics via GBE_TX_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gbe_tx_arbiter
    import gbe_tx_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int MAX_PKT_BYTES = 8192,
    parameter int GAP_CYCLES    = 4
`ifdef GBE_TX_ARB_STATS_EN
    ,
    parameter int CNT_W         = 32
`endif
)(
    input  logic                    app_clk,
    input  logic                    app_tx_rst,
    input  logic [NUM_REQ-1:0]      req_pending,
    input  logic [8*NUM_REQ-1:0]    req_data,
    input  logic [NUM_REQ-1:0]      req_dvld,
    input  logic [NUM_REQ-1:0]      req_eof,
    input  logic [32*NUM_REQ-1:0]   req_destip,
    input  logic [16*NUM_REQ-1:0]   req_destport,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic [7:0]              app_tx_data,
    output logic                    app_tx_dvld,
    output logic                    app_tx_eof,
    output logic [31:0]             app_tx_destip,
    output logic [15:0]             app_tx_destport,
    input  logic                    app_tx_afull,
    input  logic                    app_tx_overflow,
    output logic                    err_trunc,
`ifdef GBE_TX_ARB_STATS_EN
    output logic [NUM_REQ*CNT_W-1:0] stat_pkts,
    output logic [NUM_REQ*CNT_W-1:0] stat_trunc,
`endif
    output logic                    err_overflow
);

    localparam int c_PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_BW = cnt_width(MAX_PKT_BYTES);
    localparam int c_GAP_W  = cnt_width(GAP_CYCLES);
    localparam logic [c_CNT_BW-1:0] c_MAX_CNT  = c_CNT_BW'(MAX_PKT_BYTES);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST = c_PTR_W'(NUM_REQ - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_gidx;
    logic [c_PTR_W-1:0]   w_pick_idx;
    logic [c_PTR_W-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_pick;
    logic                 w_pick_vld;
    logic [c_CNT_BW-1:0]  r_cnt;
    logic [c_CNT_BW-1:0]  w_cnt_inc;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [7:0]           r_data;
    logic                 r_dvld;
    logic                 r_eof;
    logic                 r_trunc;
    logic                 r_ovf;
    logic [31:0]          r_destip;
    logic [15:0]          r_destport;
    logic [7:0]           w_lane_data;
    logic                 w_lane_eof;
    logic [31:0]          w_new_ip;
    logic [15:0]          w_new_port;
    logic [NUM_REQ-1:0]   w_ready;
    logic                 w_acc;
    logic                 w_hit_max;

    gbe_tx_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_pick (
        .pending (req_pending),
        .ptr     (r_ptr),
        .grant   (w_pick),
        .valid   (w_pick_vld)
    );

    // Lane muxes: data/eof follow the current owner, dest follows the candidate.
    always_comb begin
        w_lane_data = '0;
        w_lane_eof  = 1'b0;
        w_new_ip    = '0;
        w_new_port  = '0;
        w_pick_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_lane_data = w_lane_data | req_data[8*i +: 8];
                w_lane_eof  = w_lane_eof | req_eof[i];
            end
            if (w_pick[i]) begin
                w_new_ip   = w_new_ip | req_destip[32*i +: 32];
                w_new_port = w_new_port | req_destport[16*i +: 16];
                w_pick_idx = w_pick_idx | c_PTR_W'(i);
            end
        end
    end

    // Ready is gated by reset so no beat is consumed while the arbiter is being cleared.
    always_comb begin
        w_ready = '0;
        if (!app_tx_rst) begin
            if (r_state == XFER) begin
                w_ready = app_tx_afull ? '0 : r_grant;
            end else if (r_state == DRAIN) begin
                w_ready = r_grant;
            end
        end
    end

    assign w_acc     = |(req_dvld & w_ready);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_hit_max = (w_cnt_inc == c_MAX_CNT);
    assign w_ptr_nxt = (r_gidx == c_PTR_LAST) ? '0 : r_gidx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_pick_vld) w_state_nxt = XFER;
            XFER: begin
                if (w_acc) begin
                    if (w_lane_eof)     w_state_nxt = GAP;
                    else if (w_hit_max) w_state_nxt = DRAIN;
                end
            end
            DRAIN:   if (w_acc && w_lane_eof) w_state_nxt = GAP;
            GAP:     if (r_gap_cnt == c_GAP_LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge app_clk) begin
        if (app_tx_rst) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_ff @(posedge app_clk) begin
        if (app_tx_rst) begin
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_grant    <= '0;
            r_cnt      <= '0;
            r_gap_cnt  <= '0;
            r_data     <= '0;
            r_dvld     <= 1'b0;
            r_eof      <= 1'b0;
            r_trunc    <= 1'b0;
            r_ovf      <= 1'b0;
            r_destip   <= '0;
            r_destport <= '0;
        end else begin
            r_dvld  <= 1'b0;
            r_eof   <= 1'b0;
            r_trunc <= 1'b0;
            if (app_tx_overflow) r_ovf <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_grant    <= w_pick;
                        r_gidx     <= w_pick_idx;
                        r_destip   <= w_new_ip;
                        r_destport <= w_new_port;
                        r_cnt      <= '0;
                    end
                end
                XFER: begin
                    if (w_acc) begin
                        r_data <= w_lane_data;
                        r_dvld <= 1'b1;
                        r_cnt  <= w_cnt_inc;
                        if (w_lane_eof) begin
                            r_eof     <= 1'b1;
                            r_ptr     <= w_ptr_nxt;
                            r_grant   <= '0;
                            r_gap_cnt <= '0;
                        end else if (w_hit_max) begin
                            r_eof   <= 1'b1;
                            r_trunc <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_acc && w_lane_eof) begin
                        r_ptr     <= w_ptr_nxt;
                        r_grant   <= '0;
                        r_gap_cnt <= '0;
                    end
                end
                GAP:     r_gap_cnt <= r_gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign req_ready       = w_ready;
    assign req_grant       = r_grant;
    assign app_tx_data     = r_data;
    assign app_tx_dvld     = r_dvld;
    assign app_tx_eof      = r_eof;
    assign app_tx_destip   = r_destip;
    assign app_tx_destport = r_destport;
    assign err_trunc       = r_trunc;
    assign err_overflow    = r_ovf;

`ifdef GBE_TX_ARB_STATS_EN
    logic w_pkt_done;
    logic w_trunc_evt;

    // A truncated packet is counted once, at the truncation point, not again at its drained eof.
    assign w_pkt_done  = (r_state == XFER) && w_acc && (w_lane_eof || w_hit_max);
    assign w_trunc_evt = (r_state == XFER) && w_acc && !w_lane_eof && w_hit_max;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [CNT_W-1:0] r_pkts;
        logic [CNT_W-1:0] r_trunc_cnt;

        always_ff @(posedge app_clk) begin
            if (app_tx_rst) begin
                r_pkts      <= '0;
                r_trunc_cnt <= '0;
            end else begin
                if (w_pkt_done && r_grant[gi])  r_pkts      <= r_pkts + 1'b1;
                if (w_trunc_evt && r_grant[gi]) r_trunc_cnt <= r_trunc_cnt + 1'b1;
            end
        end

        assign stat_pkts[gi*CNT_W +: CNT_W]  = r_pkts;
        assign stat_trunc[gi*CNT_W +: CNT_W] = r_trunc_cnt;
    end
`endif

endmodule

`default_nettype wire
